// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: port ids and the BRAM command word.
package bram_arb_pkg;

   localparam int NUM_PORTS      = 2;
   localparam int ARB_DATA_WIDTH = 32;
   localparam int ARB_ADDR_WIDTH = 10;
   localparam int ARB_BE_WIDTH   = ARB_DATA_WIDTH / 8;

   typedef enum logic {
      PORT_IFETCH = 1'b0,
      PORT_DATA   = 1'b1
   } port_id_t;

   typedef struct packed {
      logic [ARB_ADDR_WIDTH-1:0] addr;
      logic                      we;
      logic [ARB_DATA_WIDTH-1:0] wdata;
      logic [ARB_BE_WIDTH-1:0]   be;
   } bram_req_t;

   function automatic port_id_t other_port(input port_id_t p);
      return port_id_t'(~p);
   endfunction

endpackage

// File: rtl/bram_arb_rsp_slot.sv
// Per-port read response register: loads BRAM data, drains on rready.
module bram_arb_rsp_slot #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_rready,
   output logic                  o_rvalid,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_busy
);

   // A load on the same edge as a drain keeps the slot full with the new word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rvalid <= 1'b0;
         o_rdata  <= '0;
      end else if (i_load) begin
         o_rvalid <= 1'b1;
         o_rdata  <= i_data;
      end else if (i_rready) begin
         o_rvalid <= 1'b0;
      end
   end

   assign o_busy = o_rvalid && !i_rready;

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between fetch (p0) and LSU (p1).
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_p0_valid,
   output logic                    o_p0_ready,
   input  logic [ADDR_WIDTH-1:0]   i_p0_addr,
   input  logic                    i_p0_we,
   input  logic [DATA_WIDTH-1:0]   i_p0_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_p0_be,
   output logic                    o_p0_rvalid,
   output logic [DATA_WIDTH-1:0]   o_p0_rdata,
   input  logic                    i_p0_rready,
   input  logic                    i_p1_valid,
   output logic                    o_p1_ready,
   input  logic [ADDR_WIDTH-1:0]   i_p1_addr,
   input  logic                    i_p1_we,
   input  logic [DATA_WIDTH-1:0]   i_p1_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_p1_be,
   output logic                    o_p1_rvalid,
   output logic [DATA_WIDTH-1:0]   o_p1_rdata,
   input  logic                    i_p1_rready,
   output logic [ADDR_WIDTH-1:0]   o_mem_addr,
   output logic [DATA_WIDTH-1:0]   o_mem_wdata,
   output logic                    o_mem_we,
   output logic [DATA_WIDTH/8-1:0] o_mem_be,
   input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

   bram_req_t [NUM_PORTS-1:0]                 req;
   logic      [NUM_PORTS-1:0]                 valid, rready, busy, elig, ready, rvalid;
   logic      [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;

   port_id_t                prio, pend_port, gnt_port;
   logic                    pend_valid, gnt_vld;
   bram_req_t               gnt_req;
   logic [ADDR_WIDTH-1:0]   last_addr;
   logic [DATA_WIDTH-1:0]   last_wdata;

   assign req[0] = '{addr: i_p0_addr, we: i_p0_we, wdata: i_p0_wdata, be: i_p0_be};
   assign req[1] = '{addr: i_p1_addr, we: i_p1_we, wdata: i_p1_wdata, be: i_p1_be};
   assign valid  = {i_p1_valid, i_p0_valid};
   assign rready = {i_p1_rready, i_p0_rready};

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      localparam port_id_t PID = port_id_t'(g);
      logic inflight;

      // A port may have only one read between grant and response register.
      assign inflight = pend_valid && (pend_port == PID);
      assign elig[g]  = valid[g] && (req[g].we || !(inflight || busy[g]));
      assign ready[g] = gnt_vld && (gnt_port == PID);

      bram_arb_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_load   (inflight),
         .i_data   (i_mem_rdata),
         .i_rready (rready[g]),
         .o_rvalid (rvalid[g]),
         .o_rdata  (rdata[g]),
         .o_busy   (busy[g])
      );
   end

   // Gating with reset keeps the BRAM quiet while the core is held in reset.
   assign gnt_vld  = i_rst_n && (|elig);
   assign gnt_port = elig[prio] ? prio : other_port(prio);
   assign gnt_req  = req[gnt_port];

   assign o_p0_ready  = ready[0];
   assign o_p1_ready  = ready[1];
   assign o_p0_rvalid = rvalid[0];
   assign o_p1_rvalid = rvalid[1];
   assign o_p0_rdata  = rdata[0];
   assign o_p1_rdata  = rdata[1];

   assign o_mem_we    = gnt_vld && gnt_req.we;
   assign o_mem_be    = gnt_vld ? gnt_req.be : '0;
   assign o_mem_addr  = gnt_vld ? gnt_req.addr  : last_addr;
   assign o_mem_wdata = gnt_vld ? gnt_req.wdata : last_wdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prio       <= PORT_IFETCH;
         pend_valid <= 1'b0;
         pend_port  <= PORT_IFETCH;
         last_addr  <= '0;
         last_wdata <= '0;
      end else begin
         pend_valid <= gnt_vld && !gnt_req.we;
         if (gnt_vld) begin
            prio       <= other_port(gnt_port);
            pend_port  <= gnt_port;
            last_addr  <= gnt_req.addr;
            last_wdata <= gnt_req.wdata;
         end
      end
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM behavioural array, transaction-level reference model, directed stimulus.
module tb_bram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_valid, p0_ready, p0_we, p0_rvalid, p0_rready;
   logic [9:0]  p0_addr;
   logic [31:0] p0_wdata, p0_rdata;
   logic [3:0]  p0_be;
   logic        p1_valid, p1_ready, p1_we, p1_rvalid, p1_rready;
   logic [9:0]  p1_addr;
   logic [31:0] p1_wdata, p1_rdata;
   logic [3:0]  p1_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_we;
   logic [3:0]  mem_be;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bram_arbiter dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_p0_valid(p0_valid), .o_p0_ready(p0_ready), .i_p0_addr(p0_addr), .i_p0_we(p0_we),
      .i_p0_wdata(p0_wdata), .i_p0_be(p0_be), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata),
      .i_p0_rready(p0_rready),
      .i_p1_valid(p1_valid), .o_p1_ready(p1_ready), .i_p1_addr(p1_addr), .i_p1_we(p1_we),
      .i_p1_wdata(p1_wdata), .i_p1_be(p1_be), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata),
      .i_p1_rready(p1_rready),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_be(mem_be),
      .i_mem_rdata(mem_rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // BRAM stand-in: command sampled mid-cycle, applied on the edge, 1-cycle read latency.
   logic [31:0] bram [1024];
   logic [31:0] mmem [1024];
   logic        c_we;
   logic [9:0]  c_addr;
   logic [31:0] c_wd;
   logic [3:0]  c_be;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         bram[i] = 32'hDEAD0000 ^ (i * 32'h00010203);
         mmem[i] = 32'hDEAD0000 ^ (i * 32'h00010203);
      end
      bram[4] = 32'h00500313;  mmem[4] = 32'h00500313;
      bram[64] = 32'h11223344; mmem[64] = 32'h11223344;
   end

   always @(negedge clk) begin
      c_we = mem_we; c_addr = mem_addr; c_wd = mem_wdata; c_be = mem_be;
   end

   always @(posedge clk) begin
      mem_rdata <= bram[c_addr];
      if (c_we)
         for (int b = 0; b < 4; b++)
            if (c_be[b]) bram[c_addr][8*b +: 8] <= c_wd[8*b +: 8];
   end

   // Reference model: who should be granted, which reads land where, and when.
   logic        mprio, gv, gp;
   logic [1:0]  mfl, mrv;
   logic [31:0] mfd [2];
   logic [31:0] mrd [2];

   initial begin
      mprio = 0; gv = 0; gp = 0; mfl = 0; mrv = 0;
   end

   always @(negedge clk) begin
      logic e0, e1;
      if (!rst_n) begin
         mprio = 0; mfl = 0; mrv = 0; gv = 0;
         chk("m_rst_rdy0", {31'b0, p0_ready}, 0);
         chk("m_rst_rdy1", {31'b0, p1_ready}, 0);
         chk("m_rst_we", {31'b0, mem_we}, 0);
         chk("m_rst_rv0", {31'b0, p0_rvalid}, 0);
         chk("m_rst_rv1", {31'b0, p1_rvalid}, 0);
      end else begin
         e0 = p0_valid && (p0_we || (!mfl[0] && !(mrv[0] && !p0_rready)));
         e1 = p1_valid && (p1_we || (!mfl[1] && !(mrv[1] && !p1_rready)));
         gv = e0 || e1;
         gp = (e0 && e1) ? mprio : e1;
         chk("m_rdy0", {31'b0, p0_ready}, {31'b0, gv && !gp});
         chk("m_rdy1", {31'b0, p1_ready}, {31'b0, gv && gp});
         chk("m_we", {31'b0, mem_we}, {31'b0, gv && (gp ? p1_we : p0_we)});
         if (gv) begin
            chk("m_addr", {22'b0, mem_addr}, {22'b0, gp ? p1_addr : p0_addr});
            if (gp ? p1_we : p0_we) begin
               chk("m_wdata", mem_wdata, gp ? p1_wdata : p0_wdata);
               chk("m_be", {28'b0, mem_be}, {28'b0, gp ? p1_be : p0_be});
            end
         end
         chk("m_rv0", {31'b0, p0_rvalid}, {31'b0, mrv[0]});
         chk("m_rv1", {31'b0, p1_rvalid}, {31'b0, mrv[1]});
         if (mrv[0]) chk("m_rd0", p0_rdata, mrd[0]);
         if (mrv[1]) chk("m_rd1", p1_rdata, mrd[1]);
      end
   end

   always @(posedge clk) begin
      logic [1:0] rr;
      logic       wr;
      logic [9:0] a;
      logic [31:0] wd;
      logic [3:0] be;
      if (rst_n) begin
         rr = {p1_rready, p0_rready};
         for (int p = 0; p < 2; p++) begin
            if (mfl[p]) begin
               mrv[p] = 1'b1;
               mrd[p] = mfd[p];
            end else if (rr[p]) begin
               mrv[p] = 1'b0;
            end
            mfl[p] = 1'b0;
         end
         if (gv) begin
            wr = gp ? p1_we : p0_we;
            a  = gp ? p1_addr : p0_addr;
            wd = gp ? p1_wdata : p0_wdata;
            be = gp ? p1_be : p0_be;
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (be[b]) mmem[a][8*b +: 8] = wd[8*b +: 8];
            end else begin
               mfl[gp] = 1'b1;
               mfd[gp] = mmem[a];
            end
            mprio = ~gp;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      rst_n = 0;
      p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0; p0_rready = 0;
      p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0; p1_rready = 0;
      repeat (2) @(negedge clk);
      chk("rst_rdy0", {31'b0, p0_ready}, 0);
      chk("rst_rdy1", {31'b0, p1_ready}, 0);
      chk("rst_we", {31'b0, mem_we}, 0);
      chk("rst_rv0", {31'b0, p0_rvalid}, 0);
      chk("rst_rv1", {31'b0, p1_rvalid}, 0);
      tick();
      rst_n = 1;

      // single p0 read, 2-cycle latency
      p0_rready = 1; p1_rready = 1;
      p0_valid = 1; p0_addr = 10'h004;
      @(negedge clk);
      chk("rd_gnt", {31'b0, p0_ready}, 1);
      chk("rd_addr", {22'b0, mem_addr}, 32'h004);
      tick();
      p0_valid = 0;
      @(negedge clk);
      chk("rd_n1_rv", {31'b0, p0_rvalid}, 0);
      tick();
      @(negedge clk);
      chk("rd_n2_rv", {31'b0, p0_rvalid}, 1);
      chk("rd_n2_data", p0_rdata, 32'h00500313);

      // contested reads after reset alternate starting with p0
      tick(); rst_n = 0;
      tick(); rst_n = 1;
      p0_valid = 1; p0_addr = 10'h010;
      p1_valid = 1; p1_addr = 10'h020;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("alt0_p0", {31'b0, p0_ready}, 1);
            chk("alt0_p1", {31'b0, p1_ready}, 0);
         end
         if (i == 1) begin
            chk("alt1_p0", {31'b0, p0_ready}, 0);
            chk("alt1_p1", {31'b0, p1_ready}, 1);
         end
         if (i == 2) chk("alt2_p0", {31'b0, p0_ready}, 1);
         tick();
      end
      p0_valid = 0; p1_valid = 0;
      repeat (3) tick();

      // byte write then read-back of the same word
      p1_valid = 1; p1_we = 1; p1_addr = 10'h040; p1_wdata = 32'h000000A5; p1_be = 4'b0001;
      @(negedge clk);
      chk("wr_gnt", {31'b0, p1_ready}, 1);
      chk("wr_we", {31'b0, mem_we}, 1);
      tick();
      p1_we = 0;
      @(negedge clk);
      chk("rbw_gnt", {31'b0, p1_ready}, 1);
      tick();
      p1_valid = 0;
      tick();
      @(negedge clk);
      chk("rbw_rv", {31'b0, p1_rvalid}, 1);
      chk("rbw_data", p1_rdata, 32'h112233A5);
      tick();

      // p0 response back-pressured while p1 keeps reading
      p0_rready = 0; p0_valid = 1; p0_addr = 10'h004;
      p1_valid = 1; p1_addr = 10'h020;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (p1_ready) cnt++;
         tick();
      end
      chk("bp_p1_gnts", cnt, 4);
      @(negedge clk);
      chk("bp_rv0", {31'b0, p0_rvalid}, 1);
      chk("bp_rd0", p0_rdata, 32'h00500313);
      chk("bp_rdy0", {31'b0, p0_ready}, 0);
      tick();
      p0_rready = 1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (p0_ready) cnt++;
         tick();
      end
      chk("bp_regrant", {31'b0, cnt > 0}, 1);
      p0_valid = 0; p1_valid = 0;
      repeat (3) tick();

      // reset while a p1 read is in flight
      p1_valid = 1; p1_addr = 10'h040;
      @(negedge clk);
      chk("rr_gnt", {31'b0, p1_ready}, 1);
      tick();
      p1_valid = 0; rst_n = 0;
      @(negedge clk);
      chk("rr_rv_in_rst", {31'b0, p1_rvalid}, 0);
      tick();
      rst_n = 1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (p1_rvalid) cnt++;
         tick();
      end
      chk("rr_no_rv", cnt, 0);
      p0_valid = 1; p0_addr = 10'h010;
      p1_valid = 1; p1_addr = 10'h020;
      @(negedge clk);
      chk("rr_prio_p0", {31'b0, p0_ready}, 1);
      chk("rr_prio_p1", {31'b0, p1_ready}, 0);
      tick();
      p0_valid = 0; p1_valid = 0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
